dla_regif_mov_queue: RTL and testbench
======================================

# dla_regif_mov_queue

Parametrised register interface and descriptor queue for a DLA buffer-move engine (GB→LB and similar paths). Software programs source, source-stride and destination registers, then writes GO. Each GO snapshots the registers into a QDEPTH-entry descriptor FIFO, which the move engine drains over a valid/ready handshake. The block sits between the regif decoder and the move engine; status (queue level, busy, overflow) is readable through CTRL.

## Interface
- SRC_AW, 13, source address width (≤16)
- SRC_SKIP_W, 13, source skip width (≤16)
- DST_AW, 11, destination address width (≤16)
- DST_SKIP_W, 6, destination skip width (≤16)
- LEN_W, 13, length width (≤16)
- ITER_W, 6, iteration width (≤16)
- QDEPTH, 4, descriptor FIFO depth, power of two, 2..16
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ctrl_wen / src0_wen / src1_wen / dest_wen  in  1 each  register write strobes
- regif_wdata  in  32  write data
- ctrl_rdata / src0_rdata / src1_rdata / dest_rdata  out  32 each  combinational readback
- cmd_valid  out  1  queue head valid
- cmd_ready  in  1  engine accepts head
- cmd_src_addr, cmd_src_skip, cmd_dst_addr, cmd_dst_skip, cmd_len, cmd_iter  out  param widths  head descriptor
- mov_done  in  1  one-cycle pulse, engine finished accepted descriptor

## Operation
- SRC0: len = wdata[16+LEN_W-1:16], addr = wdata[SRC_AW-1:0]. SRC1: iter = [16+ITER_W-1:16], skip = [SRC_SKIP_W-1:0]. DEST: skip = [16+DST_SKIP_W-1:16], addr = [DST_AW-1:0]. Readback zero-extends fields at the same positions.
- CTRL write: bit31 GO, bit30 ERR_CLR. CTRL read: [20:16] queue count, bit8 ERR, bit1 full, bit0 busy; other bits 0.
- GO = ctrl_wen & wdata[31]. Push SRC0/SRC1/DEST values as held *before* this cycle. A same-cycle SRC write affects only later GOs.
- Pop when cmd_valid & cmd_ready. cmd_valid = count≠0; cmd_* are the head entry.
- Inflight flag: set on pop, cleared on mov_done. If pop and mov_done coincide, it stays set. busy = (count≠0) | inflight.
- Full with GO and no pop: descriptor dropped, ERR set (sticky). Full with GO and pop in the same cycle: push accepted, count unchanged.
- Empty: GO with cmd_ready high is not bypassed. The entry is stored first and popped one cycle later or later.
- ERR_CLR clears ERR. If it coincides with an overflow, set wins.
- Pointers wrap modulo QDEPTH. Count is $clog2(QDEPTH)+1 bits.

## Timing
- Reset: all registers, pointers, count, inflight and ERR are 0. cmd_valid = 0, cmd_* = 0 (storage reset), rdata = 0.
- GO written at cycle N → cmd_valid high at N+1 (empty queue); count visible in ctrl_rdata at N+1.
- Pop at N → next entry on cmd_* at N+1. Pop/push-to-empty ordering holds at every depth.
- A descriptor must hold stable while cmd_valid & !cmd_ready.
- Reset mid-operation flushes the queue and inflight immediately; the engine must be reset alongside.
- mov_done with inflight = 0 is ignored.

## Configuration
- DLA_REGIF_MOV_IRQ_EN defined:
  - adds output irq (1 bit) and a sticky IRQ_PEND flag.
  - IRQ_PEND is set by mov_done when the queue is empty after that cycle. Clear by CTRL write bit29; set wins on collision.
  - irq = IRQ_PEND, registered; ctrl_rdata bit9 = IRQ_PEND.
- Not defined: no irq port, bit29 ignored, bit9 reads 0.

## Test plan
- Reset, then read all four registers → 0; cmd_valid = 0; ctrl_rdata = 0.
- Write SRC0 = 0x0040_0100, SRC1 = 0x0003_0020, DEST = 0x0002_0010, then GO with cmd_ready = 0 → next cycle cmd_valid = 1, src_addr 0x100, len 0x40, skip 0x20, iter 3, dst_addr 0x10, dst_skip 2; ctrl_rdata = 0x0001_0001.
- Five GOs with distinct addr 1..5, cmd_ready = 0, QDEPTH = 4 → count 4, full = 1, ERR = 1. Draining yields addr 1,2,3,4 in order; then ERR_CLR → ERR = 0.
- Full queue, GO with cmd_ready = 1 in the same cycle → count stays 4, ERR stays 0, new descriptor emerges last.
- Single GO, accept, hold mov_done low → busy = 1 with count 0. Pulse mov_done → busy = 0. With DLA_REGIF_MOV_IRQ_EN, irq rises the next cycle, and a CTRL bit29 write clears it.
- Assert rst with 3 entries queued and inflight set → cmd_valid = 0, busy = 0 and count = 0 immediately; a subsequent GO works normally.

Source files
------------

// File: rtl/dla_regif_mov_queue.sv
// Register interface and descriptor FIFO for the DLA buffer-move engine.
// Optional completion interrupt is enabled with `define DLA_REGIF_MOV_IRQ_EN.
module dla_regif_mov_queue #(
    parameter int unsigned SRC_AW     = 13,
    parameter int unsigned SRC_SKIP_W = 13,
    parameter int unsigned DST_AW     = 11,
    parameter int unsigned DST_SKIP_W = 6,
    parameter int unsigned LEN_W      = 13,
    parameter int unsigned ITER_W     = 6,
    parameter int unsigned QDEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_wen,
    input  logic                  src0_wen,
    input  logic                  src1_wen,
    input  logic                  dest_wen,
    input  logic [31:0]           regif_wdata,
    output logic [31:0]           ctrl_rdata,
    output logic [31:0]           src0_rdata,
    output logic [31:0]           src1_rdata,
    output logic [31:0]           dest_rdata,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [SRC_AW-1:0]     cmd_src_addr,
    output logic [SRC_SKIP_W-1:0] cmd_src_skip,
    output logic [DST_AW-1:0]     cmd_dst_addr,
    output logic [DST_SKIP_W-1:0] cmd_dst_skip,
    output logic [LEN_W-1:0]      cmd_len,
    output logic [ITER_W-1:0]     cmd_iter,
`ifdef DLA_REGIF_MOV_IRQ_EN
    output logic                  irq,
`endif
    input  logic                  mov_done
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic [SRC_AW-1:0]     src_addr;
    logic [SRC_SKIP_W-1:0] src_skip;
    logic [DST_AW-1:0]     dst_addr;
    logic [DST_SKIP_W-1:0] dst_skip;
    logic [LEN_W-1:0]      len;
    logic [ITER_W-1:0]     iter;

    logic [SRC_AW-1:0]     q_src_addr [QDEPTH];
    logic [SRC_SKIP_W-1:0] q_src_skip [QDEPTH];
    logic [DST_AW-1:0]     q_dst_addr [QDEPTH];
    logic [DST_SKIP_W-1:0] q_dst_skip [QDEPTH];
    logic [LEN_W-1:0]      q_len      [QDEPTH];
    logic [ITER_W-1:0]     q_iter     [QDEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          inflight;
    logic          err;
    logic          irq_pend;
    logic          go;
    logic          full;
    logic          pop;
    logic          push;
    logic          overflow;
    logic          unused_wdata;

    assign unused_wdata = ^regif_wdata;

    // GO snapshots the pre-write register values; a full queue only accepts if the head leaves.
    assign go        = ctrl_wen & regif_wdata[31];
    assign full      = (count == CW'(QDEPTH));
    assign cmd_valid = (count != '0);
    assign pop       = cmd_valid & cmd_ready;
    assign push      = go & (~full | pop);
    assign overflow  = go & full & ~pop;
    assign count_nxt = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_addr <= '0;
            src_skip <= '0;
            dst_addr <= '0;
            dst_skip <= '0;
            len      <= '0;
            iter     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            err      <= 1'b0;
            irq_pend <= 1'b0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_src_addr[i] <= '0;
                q_src_skip[i] <= '0;
                q_dst_addr[i] <= '0;
                q_dst_skip[i] <= '0;
                q_len[i]      <= '0;
                q_iter[i]     <= '0;
            end
        end else begin
            if (src0_wen) begin
                len      <= regif_wdata[16 +: LEN_W];
                src_addr <= regif_wdata[SRC_AW-1:0];
            end
            if (src1_wen) begin
                iter     <= regif_wdata[16 +: ITER_W];
                src_skip <= regif_wdata[SRC_SKIP_W-1:0];
            end
            if (dest_wen) begin
                dst_skip <= regif_wdata[16 +: DST_SKIP_W];
                dst_addr <= regif_wdata[DST_AW-1:0];
            end
            if (push) begin
                q_src_addr[wr_ptr] <= src_addr;
                q_src_skip[wr_ptr] <= src_skip;
                q_dst_addr[wr_ptr] <= dst_addr;
                q_dst_skip[wr_ptr] <= dst_skip;
                q_len[wr_ptr]      <= len;
                q_iter[wr_ptr]     <= iter;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            // A new acceptance outranks completion of the previous descriptor.
            if (pop) begin
                inflight <= 1'b1;
            end else if (mov_done) begin
                inflight <= 1'b0;
            end
            if (overflow) begin
                err <= 1'b1;
            end else if (ctrl_wen & regif_wdata[30]) begin
                err <= 1'b0;
            end
`ifdef DLA_REGIF_MOV_IRQ_EN
            if (mov_done & inflight & (count_nxt == '0)) begin
                irq_pend <= 1'b1;
            end else if (ctrl_wen & regif_wdata[29]) begin
                irq_pend <= 1'b0;
            end
`endif
        end
    end

`ifdef DLA_REGIF_MOV_IRQ_EN
    assign irq = irq_pend;
`endif

    assign cmd_src_addr = q_src_addr[rd_ptr];
    assign cmd_src_skip = q_src_skip[rd_ptr];
    assign cmd_dst_addr = q_dst_addr[rd_ptr];
    assign cmd_dst_skip = q_dst_skip[rd_ptr];
    assign cmd_len      = q_len[rd_ptr];
    assign cmd_iter     = q_iter[rd_ptr];

    always_comb begin
        ctrl_rdata            = '0;
        ctrl_rdata[16 +: CW]  = count;
        ctrl_rdata[9]         = irq_pend;
        ctrl_rdata[8]         = err;
        ctrl_rdata[1]         = full;
        ctrl_rdata[0]         = cmd_valid | inflight;
    end

    assign src0_rdata = (32'(len) << 16) | 32'(src_addr);
    assign src1_rdata = (32'(iter) << 16) | 32'(src_skip);
    assign dest_rdata = (32'(dst_skip) << 16) | 32'(dst_addr);

endmodule

// File: tb/tb_dla_regif_mov_queue.sv
// Scoreboard bench for dla_regif_mov_queue at default parameters (QDEPTH = 4).
module tb_dla_regif_mov_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_wen, src0_wen, src1_wen, dest_wen;
    logic [31:0] regif_wdata;
    logic [31:0] ctrl_rdata, src0_rdata, src1_rdata, dest_rdata;
    logic        cmd_valid, cmd_ready, mov_done;
    logic [12:0] cmd_src_addr, cmd_src_skip, cmd_len;
    logic [10:0] cmd_dst_addr;
    logic [5:0]  cmd_dst_skip, cmd_iter;
`ifdef DLA_REGIF_MOV_IRQ_EN
    logic        irq;
`endif

    dla_regif_mov_queue dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_wen     (ctrl_wen),
        .src0_wen     (src0_wen),
        .src1_wen     (src1_wen),
        .dest_wen     (dest_wen),
        .regif_wdata  (regif_wdata),
        .ctrl_rdata   (ctrl_rdata),
        .src0_rdata   (src0_rdata),
        .src1_rdata   (src1_rdata),
        .dest_rdata   (dest_rdata),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src_addr (cmd_src_addr),
        .cmd_src_skip (cmd_src_skip),
        .cmd_dst_addr (cmd_dst_addr),
        .cmd_dst_skip (cmd_dst_skip),
        .cmd_len      (cmd_len),
        .cmd_iter     (cmd_iter),
`ifdef DLA_REGIF_MOV_IRQ_EN
        .irq          (irq),
`endif
        .mov_done     (mov_done)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [63:0] sb [$];

    logic [12:0] s_addr, s_len, s_skip;
    logic [5:0]  s_iter, s_dskip;
    logic [10:0] s_daddr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] shadow_desc();
        return {2'b00, s_addr, s_len, s_skip, s_iter, s_daddr, s_dskip};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One register-write cycle; a GO pushes the pre-write shadow when it is expected to be accepted.
    task automatic wr(input bit c, input bit s0, input bit s1, input bit d,
                      input logic [31:0] wd, input bit accept);
        if (c && wd[31] && accept) sb.push_back(shadow_desc());
        ctrl_wen = c; src0_wen = s0; src1_wen = s1; dest_wen = d; regif_wdata = wd;
        step();
        ctrl_wen = 0; src0_wen = 0; src1_wen = 0; dest_wen = 0; regif_wdata = '0;
        if (s0) begin s_len = wd[28:16]; s_addr = wd[12:0]; end
        if (s1) begin s_iter = wd[21:16]; s_skip = wd[12:0]; end
        if (d)  begin s_dskip = wd[21:16]; s_daddr = wd[10:0]; end
    endtask

    task automatic drain(input int n);
        cmd_ready = 1;
        repeat (n) step();
        cmd_ready = 0;
    endtask

    task automatic done_pulse(input bit exp_irq);
        mov_done = 1;
        step();
        mov_done = 0;
`ifdef DLA_REGIF_MOV_IRQ_EN
        chk("irq_set", 64'(irq), 64'(exp_irq));
        chk("ctrl_irq_bit", 64'(ctrl_rdata[9]), 64'(exp_irq));
`endif
        wr(1, 0, 0, 0, 32'h2000_0000, 0);
        chk("irq_bit_clear", 64'(ctrl_rdata[9]), 64'd0);
`ifdef DLA_REGIF_MOV_IRQ_EN
        chk("irq_clear", 64'(irq), 64'd0);
`endif
    endtask

    // Head descriptor is compared against the scoreboard on every accepted handshake.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_pop", 64'd1, 64'd0);
            else chk("desc", {2'b00, cmd_src_addr, cmd_len, cmd_src_skip, cmd_iter,
                              cmd_dst_addr, cmd_dst_skip}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ctrl_wen = 0; src0_wen = 0; src1_wen = 0; dest_wen = 0;
        regif_wdata = '0; cmd_ready = 0; mov_done = 0;
        s_addr = '0; s_len = '0; s_skip = '0; s_iter = '0; s_daddr = '0; s_dskip = '0;
        repeat (2) step();
        chk("valid_in_reset", 64'(cmd_valid), 64'd0);
        rst = 0;
        step();
        chk("rst_ctrl", 64'(ctrl_rdata), 64'd0);
        chk("rst_src0", 64'(src0_rdata), 64'd0);
        chk("rst_src1", 64'(src1_rdata), 64'd0);
        chk("rst_dest", 64'(dest_rdata), 64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_head", {2'b00, cmd_src_addr, cmd_len, cmd_src_skip, cmd_iter,
                         cmd_dst_addr, cmd_dst_skip}, 64'd0);

        // Single descriptor, field placement and readback.
        wr(0, 1, 0, 0, 32'h0040_0100, 0);
        wr(0, 0, 1, 0, 32'h0003_0020, 0);
        wr(0, 0, 0, 1, 32'h0002_0010, 0);
        chk("rb_src0", 64'(src0_rdata), 64'h0040_0100);
        chk("rb_src1", 64'(src1_rdata), 64'h0003_0020);
        chk("rb_dest", 64'(dest_rdata), 64'h0002_0010);
        wr(1, 0, 0, 0, 32'h8000_0000, 1);
        chk("go_valid", 64'(cmd_valid), 64'd1);
        chk("go_src_addr", 64'(cmd_src_addr), 64'h100);
        chk("go_len", 64'(cmd_len), 64'h40);
        chk("go_skip", 64'(cmd_src_skip), 64'h20);
        chk("go_iter", 64'(cmd_iter), 64'd3);
        chk("go_dst_addr", 64'(cmd_dst_addr), 64'h10);
        chk("go_dst_skip", 64'(cmd_dst_skip), 64'd2);
        chk("go_ctrl", 64'(ctrl_rdata), 64'h0001_0001);
        drain(1);
        chk("inflight_busy", 64'(ctrl_rdata), 64'h0000_0001);
        done_pulse(1);
        chk("idle_ctrl", 64'(ctrl_rdata), 64'd0);

        // Overflow: same-cycle SRC0 write only affects later GOs; fifth GO is dropped.
        wr(0, 1, 0, 0, 32'h0000_0001, 0);
        for (int k = 1; k <= 5; k++) wr(1, 1, 0, 0, 32'h8000_0000 | 32'(k + 1), k <= 4);
        chk("ovf_src0_rb", 64'(src0_rdata), 64'h6);
        chk("ovf_ctrl", 64'(ctrl_rdata), 64'h0004_0103);
        wr(1, 0, 0, 0, 32'hC000_0000, 0);
        chk("ovf_set_wins", 64'(ctrl_rdata), 64'h0004_0103);
        drain(4);
        chk("ovf_drained", 64'(ctrl_rdata), 64'h0000_0101);
        done_pulse(1);
        chk("err_sticky", 64'(ctrl_rdata), 64'h0000_0100);
        wr(1, 0, 0, 0, 32'h4000_0000, 0);
        chk("err_clr", 64'(ctrl_rdata), 64'd0);

        // Full queue with simultaneous pop accepts the GO.
        for (int k = 0; k < 4; k++) wr(1, 1, 0, 0, 32'h8000_0000 | 32'(8'h11 + k), 1);
        chk("full_ctrl", 64'(ctrl_rdata), 64'h0004_0003);
        cmd_ready = 1;
        wr(1, 1, 0, 0, 32'h8000_0015, 1);
        cmd_ready = 0;
        chk("full_pop_push", 64'(ctrl_rdata), 64'h0004_0003);
        drain(4);
        chk("full_drained", 64'(ctrl_rdata), 64'h0000_0001);
        done_pulse(1);
        chk("full_idle", 64'(ctrl_rdata), 64'd0);

        // Empty GO with ready high is stored first, not bypassed; busy tracks inflight.
        cmd_ready = 1;
        wr(1, 0, 0, 0, 32'h8000_0000, 1);
        chk("no_bypass", 64'(ctrl_rdata), 64'h0001_0001);
        step();
        cmd_ready = 0;
        chk("busy_inflight", 64'(ctrl_rdata), 64'h0000_0001);
        repeat (3) step();
        chk("busy_hold", 64'(ctrl_rdata), 64'h0000_0001);
        done_pulse(1);
        chk("busy_clear", 64'(ctrl_rdata), 64'd0);
        done_pulse(0);
        chk("stray_done", 64'(ctrl_rdata), 64'd0);

        // Asynchronous reset with entries queued and one inflight.
        wr(1, 0, 0, 0, 32'h8000_0000, 1);
        drain(1);
        for (int k = 0; k < 3; k++) wr(1, 1, 0, 0, 32'h8000_0020 | 32'(k), 1);
        chk("pre_rst_ctrl", 64'(ctrl_rdata), 64'h0003_0001);
        rst = 1;
        #1;
        chk("rst_mid_valid", 64'(cmd_valid), 64'd0);
        chk("rst_mid_ctrl", 64'(ctrl_rdata), 64'd0);
        chk("rst_mid_src0", 64'(src0_rdata), 64'd0);
        sb.delete();
        s_addr = '0; s_len = '0; s_skip = '0; s_iter = '0; s_daddr = '0; s_dskip = '0;
        step();
        rst = 0;
        step();
        wr(0, 1, 0, 0, 32'h0005_0007, 0);
        wr(0, 0, 0, 1, 32'h003F_07FF, 0);
        wr(1, 0, 0, 0, 32'h8000_0000, 1);
        chk("post_rst_go", 64'(ctrl_rdata), 64'h0001_0001);
        drain(1);
        done_pulse(1);
        chk("post_rst_idle", 64'(ctrl_rdata), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
